// File: rtl/config.svh
// rtl/config.svh - word format shared by vec32_collector and its bench
`ifndef VEC32_CONFIG_SVH
`define VEC32_CONFIG_SVH
`define N 16
`define F 8
`endif

// File: rtl/vec32_collector.sv
// rtl/vec32_collector.sv - gathers 32 signed-magnitude words into a parallel vector
// Optional VEC32_COLLECTOR_RELU_EN: zero every negative word on input.
`include "config.svh"

module vec32_collector (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`N-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [0:31][`N-1:0]    vec,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic [5:0]             fill_count
);

  typedef enum logic {FILL, FULL} state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [0:31][`N-1:0]   vec_q, vec_d;
  logic [`N-1:0]         word;
  logic                  zero_word;

`ifdef VEC32_COLLECTOR_RELU_EN
  assign zero_word = in_data[`N-1];
`else
  // Negative zero folds to positive zero so the summation tree sees one encoding.
  assign zero_word = in_data[`N-1] && (in_data[`N-2:0] == '0);
`endif
  assign word = zero_word ? '0 : in_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    case (state_q)
      FILL: begin
        if (flush) begin
          cnt_d = 6'd0;
        end else if (in_valid) begin
          vec_d[cnt_q[4:0]] = word;
          cnt_d             = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = FULL;
        end
      end
      FULL: begin
        if (vec_ready) begin
          state_d = FILL;
          cnt_d   = 6'd0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= 6'd0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
    end
  end

  assign in_ready   = (state_q == FILL);
  assign vec_valid  = (state_q == FULL);
  assign vec        = vec_q;
  assign fill_count = cnt_q;

endmodule
